// File: rtl/traffic_pkg.sv
// Shared types for the intersection phase sequencer: phase codes, lamp patterns and phase ordering.
// TRAFFIC_NIGHT_MODE_EN adds the NIGHT phase code.
package traffic_pkg;

   typedef enum logic [2:0] {
      NS_G  = 3'd0,
      NS_Y  = 3'd1,
      AR_A  = 3'd2,
      EW_G  = 3'd3,
      EW_Y  = 3'd4,
      AR_B  = 3'd5
`ifdef TRAFFIC_NIGHT_MODE_EN
      ,
      NIGHT = 3'd6
`endif
   } phase_e;

   localparam logic [2:0] LIGHT_RED = 3'b100;
   localparam logic [2:0] LIGHT_YEL = 3'b010;
   localparam logic [2:0] LIGHT_GRN = 3'b001;
   localparam logic [2:0] LIGHT_OFF = 3'b000;

   // Illegal codes fall back to NS_G so a corrupted state re-enters the normal cycle.
   function automatic phase_e next_phase(input phase_e st);
      phase_e nxt;
      case (st)
         NS_G:    nxt = NS_Y;
         NS_Y:    nxt = AR_A;
         AR_A:    nxt = EW_G;
         EW_G:    nxt = EW_Y;
         EW_Y:    nxt = AR_B;
         AR_B:    nxt = NS_G;
         default: nxt = NS_G;
      endcase
      return nxt;
   endfunction

   // Returns {ns_lamps, ew_lamps}; unknown codes show all-red.
   function automatic logic [5:0] lamp_pair(input phase_e st);
      logic [5:0] lp;
      case (st)
         NS_G:    lp = {LIGHT_GRN, LIGHT_RED};
         NS_Y:    lp = {LIGHT_YEL, LIGHT_RED};
         AR_A:    lp = {LIGHT_RED, LIGHT_RED};
         EW_G:    lp = {LIGHT_RED, LIGHT_GRN};
         EW_Y:    lp = {LIGHT_RED, LIGHT_YEL};
         AR_B:    lp = {LIGHT_RED, LIGHT_RED};
         default: lp = {LIGHT_RED, LIGHT_RED};
      endcase
      return lp;
   endfunction

endpackage

// File: rtl/traffic_phase_ctrl_bin2bcd_99.sv
// Combinational 7-bit binary (0..99) to two-digit BCD converter.
module bin2bcd_99
   import traffic_pkg::*;
(
   input  logic [6:0] bin,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   // Highest multiple of ten not above the input selects the tens digit.
   always_comb begin
      tens = 4'd0;
      ones = 4'(bin);
      for (int i = 1; i <= 9; i++) begin
         if (bin >= 7'(i * 10)) begin
            tens = 4'(i);
            ones = 4'(bin - 7'(i * 10));
         end else begin
            tens = tens;
            ones = ones;
         end
      end
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer with pedestrian green shortening and BCD countdowns.
// Defining TRAFFIC_NIGHT_MODE_EN adds the night port and the flashing-yellow NIGHT phase.
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int T_GREEN  = 25,
   parameter int T_YELLOW = 3,
   parameter int T_ALLRED = 2,
   parameter int T_PED    = 5
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       ped_req,
`ifdef TRAFFIC_NIGHT_MODE_EN
   input  logic       night,
`endif
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic [3:0] ns_tens,
   output logic [3:0] ns_ones,
   output logic [3:0] ew_tens,
   output logic [3:0] ew_ones,
   output logic [2:0] phase
);

   if ((T_GREEN + T_YELLOW + 2 * T_ALLRED > 99) || (T_GREEN < 1) || (T_YELLOW < 1) ||
       (T_ALLRED < 1) || (T_PED < 1) || (T_PED >= T_GREEN)) begin : g_param_check
      $error("traffic_phase_ctrl: illegal timing parameters");
   end

   localparam logic [6:0] G7   = 7'(T_GREEN);
   localparam logic [6:0] Y7   = 7'(T_YELLOW);
   localparam logic [6:0] A7   = 7'(T_ALLRED);
   localparam logic [6:0] P7   = 7'(T_PED);
   localparam logic [6:0] YA7  = 7'(T_YELLOW + T_ALLRED);
   localparam logic [6:0] GYA7 = 7'(T_GREEN + T_YELLOW + T_ALLRED);

   phase_e     state_r;
   phase_e     state_s;
   logic [6:0] cnt_r;
   logic [6:0] cnt_s;
   logic       ped_pend_r;
   logic       ped_pend_s;
   logic       ped_set_s;
   logic       in_green_s;
   logic [5:0] lamps_s;
   logic [6:0] ns_rem_s;
   logic [6:0] ew_rem_s;
   logic [3:0] ns_tens_s;
   logic [3:0] ns_ones_s;
   logic [3:0] ew_tens_s;
   logic [3:0] ew_ones_s;
`ifdef TRAFFIC_NIGHT_MODE_EN
   logic       blink_r;
   logic       blink_s;
`endif

   function automatic logic [6:0] load_value(input phase_e st);
      logic [6:0] v;
      case (st)
         NS_G, EW_G: v = G7;
         NS_Y, EW_Y: v = Y7;
         AR_A, AR_B: v = A7;
         default:    v = 7'd1;
      endcase
      return v;
   endfunction

   assign ped_set_s  = ped_pend_r | ped_req;
   assign in_green_s = (state_r == NS_G) || (state_r == EW_G);
   assign phase      = state_r;

   // Next phase, counter, pending request and lamp pattern; shortening outranks a coincident tick.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
`ifdef TRAFFIC_NIGHT_MODE_EN
      blink_s = blink_r;
`endif
      if (in_green_s && ped_set_s && (cnt_r > P7)) begin
         cnt_s = P7;
      end
`ifdef TRAFFIC_NIGHT_MODE_EN
      else if (tick && (state_r == NIGHT)) begin
         if (night) begin
            blink_s = ~blink_r;
         end else begin
            state_s = AR_B;
            cnt_s   = A7;
         end
      end
      else if (tick && (cnt_r <= 7'd1) && night) begin
         state_s = NIGHT;
         cnt_s   = 7'd1;
         blink_s = 1'b1;
      end
`endif
      else if (tick && (cnt_r > 7'd1)) begin
         cnt_s = cnt_r - 7'd1;
      end
      else if (tick) begin
         state_s = next_phase(state_r);
         cnt_s   = load_value(next_phase(state_r));
      end
      else begin
         cnt_s = cnt_r;
      end

      if ((state_s != state_r) && ((state_s == NS_Y) || (state_s == EW_Y))) begin
         ped_pend_s = 1'b0;
      end
`ifdef TRAFFIC_NIGHT_MODE_EN
      else if (state_s == NIGHT) begin
         ped_pend_s = 1'b0;
      end
`endif
      else begin
         ped_pend_s = ped_set_s;
      end

`ifdef TRAFFIC_NIGHT_MODE_EN
      if (state_s == NIGHT) begin
         lamps_s = {1'b0, blink_s, 1'b0, 1'b0, blink_s, 1'b0};
      end else begin
         lamps_s = lamp_pair(state_s);
      end
`else
      lamps_s = lamp_pair(state_s);
`endif
   end

   // Phase FSM: state, counter, pedestrian latch and registered lamp outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= NS_G;
         cnt_r      <= G7;
         ped_pend_r <= 1'b0;
         ns_light   <= LIGHT_GRN;
         ew_light   <= LIGHT_RED;
`ifdef TRAFFIC_NIGHT_MODE_EN
         blink_r    <= 1'b0;
`endif
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         ped_pend_r <= ped_pend_s;
         ns_light   <= lamps_s[5:3];
         ew_light   <= lamps_s[2:0];
`ifdef TRAFFIC_NIGHT_MODE_EN
         blink_r    <= blink_s;
`endif
      end
   end

   // Seconds until each road's lamp next changes, from the current phase and counter.
   always_comb begin
      case (state_r)
         NS_G:    begin ns_rem_s = cnt_r;        ew_rem_s = cnt_r + YA7;  end
         NS_Y:    begin ns_rem_s = cnt_r;        ew_rem_s = cnt_r + A7;   end
         AR_A:    begin ns_rem_s = cnt_r + GYA7; ew_rem_s = cnt_r;        end
         EW_G:    begin ns_rem_s = cnt_r + YA7;  ew_rem_s = cnt_r;        end
         EW_Y:    begin ns_rem_s = cnt_r + A7;   ew_rem_s = cnt_r;        end
         AR_B:    begin ns_rem_s = cnt_r;        ew_rem_s = cnt_r + GYA7; end
         default: begin ns_rem_s = 7'd0;         ew_rem_s = 7'd0;         end
      endcase
   end

   bin2bcd_99 u_ns_bcd (.bin(ns_rem_s), .tens(ns_tens_s), .ones(ns_ones_s));
   bin2bcd_99 u_ew_bcd (.bin(ew_rem_s), .tens(ew_tens_s), .ones(ew_ones_s));

   // Digit registers trail the phase/counter update by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         ns_tens <= 4'(T_GREEN / 10);
         ns_ones <= 4'(T_GREEN % 10);
         ew_tens <= 4'((T_GREEN + T_YELLOW + T_ALLRED) / 10);
         ew_ones <= 4'((T_GREEN + T_YELLOW + T_ALLRED) % 10);
      end else begin
         ns_tens <= ns_tens_s;
         ns_ones <= ns_ones_s;
         ew_tens <= ew_tens_s;
         ew_ones <= ew_ones_s;
      end
   end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: a time-within-cycle reference model feeds a queue
// of expected lamps/phase/digits that a monitor process compares every clock.
module tb_traffic_phase_ctrl;
   import traffic_pkg::*;

   localparam int TG  = 25;
   localparam int TY  = 3;
   localparam int TA  = 2;
   localparam int TP  = 5;
   localparam int H   = TG + TY + TA;
   localparam int CYC = 2 * H;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       ped_req = 1'b0;
`ifdef TRAFFIC_NIGHT_MODE_EN
   logic       night = 1'b0;
`endif
   logic [2:0] ns_light, ew_light, phase;
   logic [3:0] ns_tens, ns_ones, ew_tens, ew_ones;

   traffic_phase_ctrl #(.T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .T_PED(TP)) dut (
      .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req),
`ifdef TRAFFIC_NIGHT_MODE_EN
      .night(night),
`endif
      .ns_light(ns_light), .ew_light(ew_light),
      .ns_tens(ns_tens), .ns_ones(ns_ones), .ew_tens(ew_tens), .ew_ones(ew_ones),
      .phase(phase)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] ns_l;
      logic [2:0] ew_l;
      logic [2:0] ph;
      int         ns_rem;
      int         ew_rem;
   } exp_t;

   exp_t   sb_q[$];
   int     checks = 0;
   int     errors = 0;
   int     m_t = 0;
   bit     m_pend = 1'b0;
   int     bnd[7] = '{0, TG, TG + TY, H, H + TG, H + TG + TY, CYC};
   phase_e codes[6] = '{NS_G, NS_Y, AR_A, EW_G, EW_Y, AR_B};

   function automatic int phase_of(input int t);
      for (int p = 0; p < 6; p++) if (t < bnd[p + 1]) return p;
      return 5;
   endfunction

   // A road's lamp changes at fixed seconds of the cycle; remaining time is the gap to the next one.
   function automatic int ns_rem(input int t);
      if (t < TG) return TG - t;
      if (t < TG + TY) return TG + TY - t;
      return CYC - t;
   endfunction

   function automatic int ew_rem(input int t);
      if (t < H) return H - t;
      if (t < H + TG) return H + TG - t;
      if (t < H + TG + TY) return H + TG + TY - t;
      return CYC + H - t;
   endfunction

   function automatic logic [5:0] lamps_of(input int p);
      case (p)
         0:       return 6'b001_100;
         1:       return 6'b010_100;
         3:       return 6'b100_001;
         4:       return 6'b100_010;
         default: return 6'b100_100;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
      end
   endtask

   // One clock of stimulus; the model advances and the expected post-edge view is queued.
   task automatic cycle(input bit r, input bit tk, input bit pd);
      exp_t       e;
      int         p0, p1;
      bit         pend_eff;
      logic [5:0] lp;
      @(negedge clk);
      rst = r; tick = tk; ped_req = pd;
      if (r) begin
         m_t = 0;
         m_pend = 1'b0;
         e.ns_rem = ns_rem(0);
         e.ew_rem = ew_rem(0);
      end else begin
         e.ns_rem = ns_rem(m_t);
         e.ew_rem = ew_rem(m_t);
         p0 = phase_of(m_t);
         pend_eff = m_pend | pd;
         if ((p0 == 0 || p0 == 3) && pend_eff && (bnd[p0 + 1] - m_t > TP)) m_t = bnd[p0 + 1] - TP;
         else if (tk) m_t = (m_t + 1) % CYC;
         p1 = phase_of(m_t);
         m_pend = ((p1 == 1 || p1 == 4) && (p1 != p0)) ? 1'b0 : pend_eff;
      end
      lp = lamps_of(phase_of(m_t));
      e.ns_l = lp[5:3];
      e.ew_l = lp[2:0];
      e.ph = 3'(codes[phase_of(m_t)]);
      sb_q.push_back(e);
   endtask

   // Monitor: sample just after each rising edge and compare against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("ns_light", int'(ns_light), int'(e.ns_l));
            check("ew_light", int'(ew_light), int'(e.ew_l));
            check("phase", int'(phase), int'(e.ph));
            check("ns_digits", int'(ns_tens) * 10 + int'(ns_ones), e.ns_rem);
            check("ew_digits", int'(ew_tens) * 10 + int'(ew_ones), e.ew_rem);
            check("bcd_ones_range", int'(ns_ones > 4'd9 || ew_ones > 4'd9), 0);
         end
      end
   end

   initial begin
      repeat (3) cycle(1'b1, 1'b0, 1'b0);
      repeat (25) cycle(1'b0, 1'b1, 1'b0);          // into NS_Y
      repeat (2) cycle(1'b0, 1'b0, 1'b0);
      repeat (35) cycle(1'b0, 1'b1, 1'b0);          // full cycle back to NS_G
      cycle(1'b0, 1'b0, 1'b0);
      repeat (5) cycle(1'b0, 1'b1, 1'b0);           // cnt 20
      cycle(1'b0, 1'b0, 1'b1);                      // shortened to 5
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);                      // cnt 4
      cycle(1'b0, 1'b0, 1'b1);                      // no shortening below T_PED
      repeat (4) cycle(1'b0, 1'b1, 1'b0);           // into NS_Y, pending cleared
      cycle(1'b0, 1'b0, 1'b1);                      // request during yellow
      repeat (5) cycle(1'b0, 1'b1, 1'b0);           // EW_G entered at full length
      repeat (2) cycle(1'b0, 1'b0, 1'b0);           // then shortened
      repeat (10) cycle(1'b0, 1'b1, 1'b0);          // back to NS_G
      cycle(1'b0, 1'b1, 1'b1);                      // tick and request together
      repeat (35) cycle(1'b0, 1'b1, 1'b0);          // into EW_Y
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);                      // reset with request pending
      repeat (30) cycle(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4000; i++) begin
         cycle($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      end
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("queue_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
